// File: rtl/riscv_core_hazard_ctrl_if.sv
// D-stage hazard inputs, bypass/stall controls and mul-div handshake between
// the pipeline datapath (master) and the hazard controller (slave).
interface riscv_core_hazard_ctrl_if;
  logic       inst_val_Dhl;
  logic       rs1_en_Dhl, rs2_en_Dhl;
  logic [4:0] rs1_addr_Dhl, rs2_addr_Dhl, rd_addr_Dhl;
  logic       rd_wen_Dhl, is_load_Dhl, is_muldiv_Dhl, squash_Dhl;
  logic       dmemresp_val_Mhl;
  logic       muldivreq_rdy, muldivresp_val;
  logic [1:0] rs1_mux_sel_Dhl, rs2_mux_sel_Dhl;
  logic       stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl;
  logic       muldivreq_val, muldivresp_rdy;
  logic       rf_wen_Whl;
  logic [4:0] rf_waddr_Whl;

  modport master (
    output inst_val_Dhl, rs1_en_Dhl, rs2_en_Dhl, rs1_addr_Dhl, rs2_addr_Dhl,
           rd_addr_Dhl, rd_wen_Dhl, is_load_Dhl, is_muldiv_Dhl, squash_Dhl,
           dmemresp_val_Mhl, muldivreq_rdy, muldivresp_val,
    input  rs1_mux_sel_Dhl, rs2_mux_sel_Dhl, stall_Fhl, stall_Dhl, stall_Xhl,
           stall_Mhl, stall_Whl, muldivreq_val, muldivresp_rdy, rf_wen_Whl,
           rf_waddr_Whl
  );

  modport slave (
    input  inst_val_Dhl, rs1_en_Dhl, rs2_en_Dhl, rs1_addr_Dhl, rs2_addr_Dhl,
           rd_addr_Dhl, rd_wen_Dhl, is_load_Dhl, is_muldiv_Dhl, squash_Dhl,
           dmemresp_val_Mhl, muldivreq_rdy, muldivresp_val,
    output rs1_mux_sel_Dhl, rs2_mux_sel_Dhl, stall_Fhl, stall_Dhl, stall_Xhl,
           stall_Mhl, stall_Whl, muldivreq_val, muldivresp_rdy, rf_wen_Whl,
           rf_waddr_Whl
  );
endinterface

// File: rtl/riscv_core_hazard_ctrl.sv
// 5-stage RISC-V hazard unit: X/M/W scoreboard, bypass select, load-use and
// mul-div stalls, and the mul-div request/response sequencer.
module riscv_core_hazard_ctrl_byp (
  input  logic            en,
  input  logic [4:0]      addr,
  input  logic [2:0]      cand,   // [0]=X, [1]=M, [2]=W
  input  logic [2:0][4:0] rd,
  output logic [1:0]      sel
);
  // Later assignments win, giving X > M > W priority.
  always_comb begin
    sel = 2'd3;
    if (en && addr != 5'd0) begin
      if (cand[2] && rd[2] == addr) sel = 2'd2;
      if (cand[1] && rd[1] == addr) sel = 2'd1;
      if (cand[0] && rd[0] == addr) sel = 2'd0;
    end
  end
endmodule

module riscv_core_hazard_ctrl #(
  parameter int NUM_OPS = 2
) (
  input logic clk,
  input logic reset,
  riscv_core_hazard_ctrl_if.slave hz
);
  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] rd;
    logic       load;
    logic       muldiv;
  } stage_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} md_state_e;

  stage_t    x_q, m_q, w_q;
  md_state_e md_state;
  logic      req_q, wait_q;
  logic      stall_m, stall_x, stall_d, md_done, load_use;

  logic [NUM_OPS-1:0]      rs_en;
  logic [NUM_OPS-1:0][4:0] rs_addr;
  logic [NUM_OPS-1:0][1:0] rs_sel;
  logic [2:0]              cand;
  logic [2:0][4:0]         cand_rd;

  always_comb begin
    stall_m  = m_q.val & m_q.load & ~hz.dmemresp_val_Mhl;
    md_done  = wait_q & hz.muldivresp_val & ~stall_m;
    stall_x  = stall_m | (x_q.val & x_q.muldiv & ~md_done);
    load_use = x_q.val & x_q.wen & x_q.load & (x_q.rd != 5'd0) &
               ((hz.rs1_en_Dhl & (hz.rs1_addr_Dhl == x_q.rd)) |
                (hz.rs2_en_Dhl & (hz.rs2_addr_Dhl == x_q.rd)));
    stall_d  = hz.inst_val_Dhl & (stall_x | load_use);
  end

  // A load in X has no data yet, so it never feeds the X bypass.
  assign cand    = {w_q.val & w_q.wen, m_q.val & m_q.wen, x_q.val & x_q.wen & ~x_q.load};
  assign cand_rd = {w_q.rd, m_q.rd, x_q.rd};
  assign rs_en   = {hz.rs2_en_Dhl, hz.rs1_en_Dhl};
  assign rs_addr = {hz.rs2_addr_Dhl, hz.rs1_addr_Dhl};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    riscv_core_hazard_ctrl_byp u_byp (
      .en(rs_en[g]), .addr(rs_addr[g]), .cand(cand), .rd(cand_rd), .sel(rs_sel[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q     <= m_q;
      w_q.val <= m_q.val & ~stall_m;
      if (!stall_m) begin
        m_q     <= x_q;
        m_q.val <= x_q.val & ~stall_x;
      end
      // Squash and D stall both turn the X slot into a bubble.
      if (!stall_x)
        x_q <= '{val:    hz.inst_val_Dhl & ~hz.squash_Dhl & ~stall_d,
                 wen:    hz.rd_wen_Dhl,
                 rd:     hz.rd_addr_Dhl,
                 load:   hz.is_load_Dhl,
                 muldiv: hz.is_muldiv_Dhl};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= IDLE;
      req_q    <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      case (md_state)
        IDLE: if (x_q.val && x_q.muldiv) begin
          md_state <= REQ;
          req_q    <= 1'b1;
        end
        REQ: if (hz.muldivreq_rdy) begin
          md_state <= WAIT;
          req_q    <= 1'b0;
          wait_q   <= 1'b1;
        end
        WAIT: if (md_done) begin
          md_state <= IDLE;
          wait_q   <= 1'b0;
        end
        default: begin
          md_state <= IDLE;
          req_q    <= 1'b0;
          wait_q   <= 1'b0;
        end
      endcase
    end
  end

  assign hz.rs1_mux_sel_Dhl = rs_sel[0];
  assign hz.rs2_mux_sel_Dhl = rs_sel[1];
  assign hz.stall_Fhl       = stall_d;
  assign hz.stall_Dhl       = stall_d;
  assign hz.stall_Xhl       = stall_x;
  assign hz.stall_Mhl       = stall_m;
  assign hz.stall_Whl       = 1'b0;
  assign hz.muldivreq_val   = req_q;
  assign hz.muldivresp_rdy  = wait_q & ~stall_m;
  assign hz.rf_wen_Whl      = w_q.val & w_q.wen & (w_q.rd != 5'd0);
  assign hz.rf_waddr_Whl    = w_q.rd;
endmodule
